// File: rtl/debug_capture_if.sv
// Probe, trigger-setup and readout signals of debug_capture; master drives probes/controls, slave is the analyser.
// Defining DEBUG_CAPTURE_EXT_TRIG_EN adds the ext_trig input.
interface debug_capture_if #(
  parameter int WORDLEN  = 24,
  parameter int NUMWORDS = 2,
  parameter int ADDR_W   = 12
);
  localparam int W = WORDLEN * NUMWORDS;

  logic              data_in_valid;
  logic [W-1:0]      data_in;
  logic              arm;
  logic [ADDR_W-1:0] pretrig;
  logic [W-1:0]      trig_mask;
  logic [W-1:0]      trig_value;
  logic              next;
  logic [W-1:0]      data_out;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] trig_addr;
  logic [2:0]        state;
  logic              done;
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
  logic              ext_trig;
`endif

  modport master (
    output data_in_valid, data_in, arm, pretrig, trig_mask, trig_value, next,
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
    output ext_trig,
`endif
    input  data_out, rd_idx, trig_addr, state, done
  );

  modport slave (
    input  data_in_valid, data_in, arm, pretrig, trig_mask, trig_value, next,
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
    input  ext_trig,
`endif
    output data_out, rd_idx, trig_addr, state, done
  );
endinterface

// File: rtl/debug_capture.sv
// On-chip logic analyser: circular sample buffer with masked-pattern trigger and pre-trigger window.
// Defining DEBUG_CAPTURE_EXT_TRIG_EN adds an edge-triggered external trigger input.
module debug_capture #(
  parameter int WORDLEN  = 24,
  parameter int NUMWORDS = 2,
  parameter int ADDR_W   = 12
) (
  input logic            clk,
  input logic            reset,
  debug_capture_if.slave bus
);
  localparam int W = WORDLEN * NUMWORDS;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              arm_q, next_q;
  logic [W-1:0]      data_out_q;
  logic [W-1:0]      mem [DEPTH];

  logic              we;
  logic              arm_edge, next_edge, sample, match, trig_hit;
  logic [ADDR_W:0]   cnt_inc, post_len;
  logic [ADDR_W-1:0] rd_addr;

  assign arm_edge  = bus.arm && !arm_q;
  assign next_edge = bus.next && !next_q;
  assign sample    = bus.data_in_valid;
  assign match     = ((bus.data_in ^ bus.trig_value) & bus.trig_mask) == '0;
  assign cnt_inc   = cnt_q + 1'b1;
  // Samples still to store from the trigger onwards, trigger included.
  assign post_len  = DEPTH_C - {1'b0, p_q};
  assign rd_addr   = trig_addr_q - p_q + rd_idx_q;

`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
  logic ext_q, pend_q, pend_d, ext_edge;
  assign ext_edge = bus.ext_trig && !ext_q;
  assign trig_hit = match || pend_q || ext_edge;
`else
  assign trig_hit = match;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    p_d         = p_q;
    trig_addr_d = trig_addr_q;
    rd_idx_d    = rd_idx_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    we          = 1'b0;
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
    pend_d      = pend_q;
`endif
    if (arm_edge) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
      p_d      = bus.pretrig;
      done_d   = 1'b0;
      rd_idx_d = '0;
      state_d  = (bus.pretrig == '0) ? S_ARMED : S_PRE;
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
      pend_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_PRE: if (sample) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == {1'b0, p_q}) state_d = S_ARMED;
        end
        S_ARMED: if (sample) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = (ADDR_W+1)'(1);
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
            pend_d      = 1'b0;
`endif
            if (post_len == (ADDR_W+1)'(1)) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              rd_idx_d = '0;
            end else begin
              state_d = S_POST;
            end
          end
        end
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
        else if (ext_edge) pend_d = 1'b1;
`endif
        S_POST: if (sample) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == post_len) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            rd_idx_d = '0;
          end
        end
        S_DONE: if (next_edge) rd_idx_d = rd_idx_q + 1'b1;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      p_q         <= '0;
      trig_addr_q <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      arm_q       <= 1'b0;
      next_q      <= 1'b0;
      data_out_q  <= '0;
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
      ext_q       <= 1'b0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      p_q         <= p_d;
      trig_addr_q <= trig_addr_d;
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      arm_q       <= bus.arm;
      next_q      <= bus.next;
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
      ext_q       <= bus.ext_trig;
      pend_q      <= pend_d;
`endif
      // Readout register only moves in DONE, so the last word holds until the next arm.
      if (arm_edge)               data_out_q <= '0;
      else if (state_q == S_DONE) data_out_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_idx    = rd_idx_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.state     = state_q;
  assign bus.done      = done_q;
endmodule
